multi_cycle_ctrl: RTL and testbench

//  Main control FSM for the multi-cycle MIPS datapath. Sequences IR/PC/regfile/memory strobes per instruction
//  and drives ALUOp (00 add, 01 sub, 10 funct, 11 lui) into the ALU-control decoder. Stalls on a memory

---
 rtl/multi_cycle_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for a multi-cycle MIPS datapath: sequences fetch/decode/execute strobes per
// instruction, stalls on the memory ready handshake and halts on illegal encodings or memory timeout.
module multi_cycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_LUI   = 6'b001111,
    parameter int         MEM_TMO  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_tmo
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_LUI_EX   = 4'd9,
        S_LUI_WB   = 4'd10,
        S_HALT     = 4'd15
    } state_t;

    localparam int CW = $clog2(MEM_TMO + 1);

    state_t        state_reg, state_next;
    logic [CW-1:0] wait_reg;
    logic          illegal_reg, tmo_reg;
    logic          waiting, tmo_hit, illegal_hit, funct_ok;

    assign waiting = (state_reg == S_FETCH) || (state_reg == S_MEM_RD) || (state_reg == S_MEM_WR);
    // The MEM_TMO-th consecutive not-ready cycle is the one that times out.
    assign tmo_hit = waiting && !mem_ready && (wait_reg == CW'(MEM_TMO - 1));

    always_comb begin
        funct_ok = 1'b0;
        case (funct)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h26, 6'h00: funct_ok = 1'b1;
            default:                                         funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        illegal_hit = 1'b0;
        case (state_reg)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_RTYPE: begin
                        state_next  = funct_ok ? S_EXEC_R : S_HALT;
                        illegal_hit = !funct_ok;
                    end
                    OP_BEQ:  state_next = S_BRANCH;
                    OP_LUI:  state_next = S_LUI_EX;
                    default: begin
                        state_next  = S_HALT;
                        illegal_hit = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_next = S_MEM_WB;
            S_MEM_WB:   state_next = S_FETCH;
            S_MEM_WR:   if (mem_ready) state_next = S_FETCH;
            S_EXEC_R:   state_next = S_R_WB;
            S_R_WB:     state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_LUI_EX:   state_next = S_LUI_WB;
            S_LUI_WB:   state_next = S_FETCH;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_HALT;
        endcase
        if (tmo_hit) state_next = S_HALT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_FETCH;
            wait_reg    <= '0;
            illegal_reg <= 1'b0;
            tmo_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg) wait_reg <= '0;
            else if (waiting && !mem_ready) wait_reg <= wait_reg + CW'(1);
            if (illegal_hit) illegal_reg <= 1'b1;
            if (tmo_hit) tmo_reg <= 1'b1;
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        case (state_reg)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE:   ALUSrcB = 2'b11;
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_R_WB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
            S_LUI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
            end
            S_LUI_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // Reset must never let a half-finished instruction commit architectural state.
        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
        end
    end

    assign state      = state_reg;
    assign illegal_op = illegal_reg;
    assign mem_tmo    = tmo_reg;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboarded random bench for multi_cycle_ctrl: per-instruction expectations are derived from
// instruction class and wait counts; halt, timeout and reset behaviour are exercised directly.
module tb_multi_cycle_ctrl;

    localparam int MEM_TMO = 16;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_LUI = 6'b001111;

    logic       clk = 1'b0;
    logic       rst, mem_ready;
    logic [5:0] opcode, funct;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic       instr_done, illegal_op, mem_tmo;

    multi_cycle_ctrl #(.MEM_TMO(MEM_TMO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state(state), .instr_done(instr_done),
        .illegal_op(illegal_op), .mem_tmo(mem_tmo)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        string name;
        int cycles, mr, mw, rw, pcw, irw, pcc, dst, m2r, mask;
    } exp_t;
    exp_t exp_q[$];
    bit   mon_en = 1'b0;

    // Expected per-instruction totals, built from class latency and wait counts.
    function automatic exp_t model(input string nm, input logic [5:0] op, input int wf, input int wm);
        exp_t e;
        e.name = nm; e.pcw = 1; e.irw = 1; e.mr = 1 + wf; e.mw = 0; e.rw = 0;
        e.pcc = 0; e.dst = 0; e.m2r = 0;
        case (op)
            OP_LW:   begin e.cycles = 5 + wf + wm; e.mr += 1 + wm; e.rw = 1; e.m2r = 1; e.mask = 1; end
            OP_SW:   begin e.cycles = 4 + wf + wm; e.mw = 1 + wm; e.mask = 1; end
            OP_BEQ:  begin e.cycles = 3 + wf; e.pcc = 1; e.mask = 2; end
            OP_LUI:  begin e.cycles = 4 + wf; e.rw = 1; e.mask = 8; end
            default: begin e.cycles = 4 + wf; e.rw = 1; e.dst = 1; e.mask = 4; end
        endcase
        return e;
    endfunction

    // Monitor: accumulates strobe activity and scores it against the queue at each instr_done.
    initial begin
        int c, mr, mw, rw, pcw, irw, pcc, dst, m2r, mask;
        exp_t e;
        c = 0; mr = 0; mw = 0; rw = 0; pcw = 0; irw = 0; pcc = 0; dst = 0; m2r = 0; mask = 0;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                c = 0; mr = 0; mw = 0; rw = 0; pcw = 0; irw = 0; pcc = 0; dst = 0; m2r = 0; mask = 0;
            end else begin
                c++;
                mr  += int'(MemRead);
                mw  += int'(MemWrite && IorD);
                rw  += int'(RegWrite);
                pcw += int'(PCWrite);
                irw += int'(IRWrite);
                pcc += int'(PCWriteCond && PCSource == 2'b01);
                dst += int'(RegWrite && RegDst);
                m2r += int'(RegWrite && MemtoReg);
                if (ALUSrcA) mask |= (1 << ALUOp);
                if (instr_done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_instr_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk({e.name, "_cycles"}, c, e.cycles);
                        chk({e.name, "_memread"}, mr, e.mr);
                        chk({e.name, "_memwrite"}, mw, e.mw);
                        chk({e.name, "_regwrite"}, rw, e.rw);
                        chk({e.name, "_pcwrite"}, pcw, e.pcw);
                        chk({e.name, "_irwrite"}, irw, e.irw);
                        chk({e.name, "_pcwritecond"}, pcc, e.pcc);
                        chk({e.name, "_regdst"}, dst, e.dst);
                        chk({e.name, "_memtoreg"}, m2r, e.m2r);
                        chk({e.name, "_aluop"}, mask, e.mask);
                        $display("txn %-4s cycles=%0d memread=%0d memwrite=%0d regwrite=%0d aluop_mask=%0d",
                                 e.name, c, mr, mw, rw, mask);
                    end
                    c = 0; mr = 0; mw = 0; rw = 0; pcw = 0; irw = 0; pcc = 0; dst = 0; m2r = 0; mask = 0;
                end
            end
        end
    end

    // Called #1 after a posedge with the DUT in FETCH; returns #1 after the edge that ends the instruction.
    task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                             input int wf, input int wm);
        int fc, mc, guard;
        bit done;
        exp_q.push_back(model(nm, op, wf, wm));
        opcode = op; funct = fn; fc = 0; mc = 0; guard = 0; done = 1'b0;
        while (!done && guard < 200) begin
            case (state)
                4'd0:       begin mem_ready = (fc == wf); fc++; end
                4'd3, 4'd5: begin mem_ready = (mc == wm); mc++; end
                default:    mem_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            done = instr_done;
            @(posedge clk); #1;
            guard++;
        end
        if (!done) chk({nm, "_completion"}, 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_state", int'(state), 0);
        chk("reset_flags", int'({illegal_op, mem_tmo}), 0);
        chk("reset_strobes", int'({PCWrite, PCWriteCond, MemWrite, IRWrite, RegWrite}), 0);
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0;
    endtask

    // Runs until HALT, checking how many cycles preceded it and which flag got set.
    task automatic halt_case(input string nm, input logic [5:0] op, input logic [5:0] fn,
                             input logic fetch_ready, input int exp_n, input int exp_ill, input int exp_tmo);
        int n;
        bit bad;
        opcode = op; funct = fn; n = 0;
        while (state != 4'd15 && n < 100) begin
            mem_ready = (state == 4'd0) ? fetch_ready : 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_cycles_to_halt"}, n, exp_n);
        chk({nm, "_illegal_op"}, int'(illegal_op), exp_ill);
        chk({nm, "_mem_tmo"}, int'(mem_tmo), exp_tmo);
        bad = 1'b0;
        repeat (4) begin
            mem_ready = 1'b1;
            @(negedge clk);
            bad |= PCWrite | PCWriteCond | MemWrite | IRWrite | RegWrite | MemRead | instr_done | (state != 4'd15);
            bad |= (int'(illegal_op) != exp_ill) | (int'(mem_tmo) != exp_tmo);
            @(posedge clk); #1;
        end
        chk({nm, "_halt_hold"}, int'(bad), 0);
        $display("txn halt %s cycles=%0d illegal_op=%0d mem_tmo=%0d", nm, n, illegal_op, mem_tmo);
        do_reset();
    endtask

    initial begin
        logic [5:0] legal_fn [7];
        logic [5:0] ops [5];
        int k, wf, wm, n;
        legal_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h26, 6'h00};
        ops      = '{OP_LW, OP_SW, OP_BEQ, OP_LUI, OP_R};
        rst = 1'b1; mem_ready = 1'b0; opcode = '0; funct = '0;
        @(posedge clk); #1;
        do_reset();

        mon_en = 1'b1;
        run_instr("lw", OP_LW, 6'h00, 0, 0);
        run_instr("sw", OP_SW, 6'h00, 0, 3);
        run_instr("add", OP_R, 6'h20, 0, 0);
        run_instr("beq", OP_BEQ, 6'h00, 0, 0);
        run_instr("lui", OP_LUI, 6'h00, 2, 0);
        run_instr("lw", OP_LW, 6'h00, MEM_TMO - 1, MEM_TMO - 1);
        for (int i = 0; i < 40; i++) begin
            k  = $urandom_range(0, 4);
            wf = ($urandom_range(0, 9) == 0) ? MEM_TMO - 1 : $urandom_range(0, 3);
            wm = ($urandom_range(0, 9) == 0) ? MEM_TMO - 1 : $urandom_range(0, 3);
            case (k)
                0: run_instr("lw", OP_LW, 6'($urandom), wf, wm);
                1: run_instr("sw", OP_SW, 6'($urandom), wf, wm);
                2: run_instr("beq", OP_BEQ, 6'($urandom), wf, 0);
                3: run_instr("lui", OP_LUI, 6'($urandom), wf, 0);
                default: run_instr("r", OP_R, legal_fn[$urandom_range(0, 6)], wf, 0);
            endcase
        end
        mon_en = 1'b0;
        chk("scoreboard_drained", exp_q.size(), 0);

        halt_case("jump", 6'b000010, 6'h20, 1'b1, 2, 1, 0);
        halt_case("funct03", OP_R, 6'h03, 1'b1, 2, 1, 0);
        halt_case("fetch_tmo", OP_LW, 6'h00, 1'b0, MEM_TMO, 0, 1);
        halt_case("memrd_tmo", OP_LW, 6'h00, 1'b1, 3 + MEM_TMO, 0, 1);
        halt_case("memwr_tmo", OP_SW, 6'h00, 1'b1, 3 + MEM_TMO, 0, 1);
        chk("flags_cleared_after_reset", int'({illegal_op, mem_tmo}), 0);

        // Reset while a store is waiting in MEM_WR.
        opcode = OP_SW; n = 0;
        while (state != 4'd5 && n < 20) begin
            mem_ready = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        chk("memwr_write_before_reset", int'(MemWrite), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("memwr_write_during_reset", int'(MemWrite), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("memwr_reset_to_fetch", int'(state), 0);
        chk("memwr_reset_flags", int'({illegal_op, mem_tmo}), 0);
        $display("txn reset_in_memwr state=%0d", state);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
